// File: rtl/tcam_if.sv
// tcam_if: lookup/write bus of the route TCAM.
//   addr_in     : on write {if_idx[3:0], netmask, prefix}; on lookup the low WIDTH bits are the address
//   wr_en       : 1 = write entry, 0 = lookup
//   wr_index    : entry slot to write
//   addr_out    : network (prefix & netmask) of the matched entry
//   if_idx      : egress interface of the matched entry
//   prefix_size : popcount of the matched netmask
//   valid       : the last lookup matched an entry
// master drives requests (the forwarding path); slave is the TCAM.
interface tcam_if #(
    parameter int WIDTH = 32
);
    logic [2*WIDTH+3:0] addr_in;
    logic               wr_en;
    logic [7:0]         wr_index;
    logic [WIDTH-1:0]   addr_out;
    logic [3:0]         if_idx;
    logic [7:0]         prefix_size;
    logic               valid;

    modport master (
        output addr_in, wr_en, wr_index,
        input  addr_out, if_idx, prefix_size, valid
    );

    modport slave (
        input  addr_in, wr_en, wr_index,
        output addr_out, if_idx, prefix_size, valid
    );
endinterface

// File: rtl/tcam.sv
// tcam: brute-force ternary CAM for IPv4 longest-prefix-match route lookup.
// Every stored entry is compared against the lookup address in parallel; the
// match with the most netmask 1-bits wins (lowest index on a tie) and is
// registered onto the bus one clock later.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (clears table and outputs)
//   bus : tcam_if slave modport (write/lookup request, registered result)
module tcam #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8
) (
    input  logic  clk,
    input  logic  rst,
    tcam_if.slave bus
);

    localparam int         IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [8:0] SIZE_LIM = 9'(SIZE);

    // Route table. Popcount of each mask is stored at write time so the
    // lookup path only has to compare precomputed lengths.
    logic [WIDTH-1:0] prefix_q [SIZE];
    logic [WIDTH-1:0] mask_q   [SIZE];
    logic [3:0]       if_q     [SIZE];
    logic [7:0]       pcnt_q   [SIZE];
    logic [SIZE-1:0]  vld_q;

    logic [WIDTH-1:0] wr_prefix;
    logic [WIDTH-1:0] wr_mask;
    logic [3:0]       wr_if;
    logic [WIDTH-1:0] look_addr;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_slot;

    logic             best_hit;
    logic [WIDTH-1:0] best_addr;
    logic [3:0]       best_if;
    logic [7:0]       best_pcnt;

    function automatic logic [7:0] popcount(input logic [WIDTH-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

    assign wr_prefix = bus.addr_in[WIDTH-1:0];
    assign wr_mask   = bus.addr_in[2*WIDTH-1:WIDTH];
    assign wr_if     = bus.addr_in[2*WIDTH+3:2*WIDTH];
    assign look_addr = bus.addr_in[WIDTH-1:0];
    // Out-of-range slots are dropped rather than aliased onto a low slot.
    assign wr_hit    = ({1'b0, bus.wr_index} < SIZE_LIM);
    assign wr_slot   = bus.wr_index[IDX_W-1:0];

    // Priority search: scanning upward and replacing only on a strictly
    // longer prefix leaves the lowest index in place on a tie.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop;
        // a path that skips an assignment would infer a latch.
        best_hit  = 1'b0;
        best_addr = '0;
        best_if   = '0;
        best_pcnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            // NOTE: blocking assignments here are intentional -- later
            // iterations must see the running best from earlier ones.
            if (vld_q[i] && (((look_addr ^ prefix_q[i]) & mask_q[i]) == '0) &&
                (!best_hit || (pcnt_q[i] > best_pcnt))) begin
                best_hit  = 1'b1;
                best_addr = prefix_q[i] & mask_q[i];
                best_if   = if_q[i];
                best_pcnt = pcnt_q[i];
            end
        end
    end

    // Table update. if_idx 4'hF is the delete code: the slot is still loaded
    // but its valid flag is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            // NOTE: the table contents themselves are cleared on reset, not
            // only the valid flags, so no stale route survives a reset.
            for (int i = 0; i < SIZE; i++) begin
                prefix_q[i] <= '0;
                mask_q[i]   <= '0;
                if_q[i]     <= '0;
                pcnt_q[i]   <= '0;
            end
        end else if (bus.wr_en && wr_hit) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values.
            prefix_q[wr_slot] <= wr_prefix;
            mask_q[wr_slot]   <= wr_mask;
            if_q[wr_slot]     <= wr_if;
            pcnt_q[wr_slot]   <= popcount(wr_mask);
            vld_q[wr_slot]    <= (wr_if != 4'hF);
        end
    end

    // Result register. A write cycle performs no lookup: valid drops and
    // the remaining result fields hold their previous values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid       <= 1'b0;
            bus.addr_out    <= '0;
            bus.if_idx      <= '0;
            bus.prefix_size <= '0;
        end else if (bus.wr_en) begin
            bus.valid       <= 1'b0;
        end else begin
            bus.valid       <= best_hit;
            bus.addr_out    <= best_addr;
            bus.if_idx      <= best_if;
            bus.prefix_size <= best_pcnt;
        end
    end

endmodule

// File: tb/tb_tcam.sv
// tb_tcam: self-checking bench for tcam. A directed table of writes/lookups
// with hand-derived expected results, followed by randomized traffic checked
// against a behavioural longest-prefix-match model.
module tb_tcam;

    localparam int WIDTH = 32;
    localparam int SIZE  = 8;

    typedef enum logic [1:0] {OP_WR, OP_LK, OP_RST} op_e;

    typedef struct {
        op_e         op;
        logic [7:0]  idx;
        logic [31:0] d;      // prefix on write, address on lookup
        logic [31:0] m;
        logic [3:0]  f;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [3:0]  e_if;
        logic [7:0]  e_ps;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tcam_if #(.WIDTH(WIDTH)) bus ();

    tcam #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state.
    bit          m_vld [SIZE];
    logic [31:0] m_pre [SIZE];
    logic [31:0] m_msk [SIZE];
    logic [3:0]  m_if  [SIZE];
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [3:0]  exp_if;
    logic [7:0]  exp_ps;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic void add(input op_e op, input logic [7:0] idx, input logic [31:0] d,
                                input logic [31:0] m, input logic [3:0] f, input logic ev,
                                input logic [31:0] ea, input logic [3:0] ei, input logic [7:0] ep);
        vec_t v;
        v.op = op; v.idx = idx; v.d = d; v.m = m; v.f = f;
        v.e_valid = ev; v.e_addr = ea; v.e_if = ei; v.e_ps = ep;
        tbl.push_back(v);
    endfunction

    // Longest prefix first, lowest index first within a length.
    task automatic model_lookup(input logic [31:0] a);
        bit found = 0;
        exp_valid = 1'b0; exp_addr = '0; exp_if = '0; exp_ps = '0;
        for (int len = WIDTH; len >= 0 && !found; len--) begin
            for (int i = 0; i < SIZE && !found; i++) begin
                if (m_vld[i] && $countones(m_msk[i]) == len && (a & m_msk[i]) == (m_pre[i] & m_msk[i])) begin
                    found     = 1;
                    exp_valid = 1'b1;
                    exp_addr  = m_pre[i] & m_msk[i];
                    exp_if    = m_if[i];
                    exp_ps    = 8'(len);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) begin
            m_vld[i] = 0; m_pre[i] = '0; m_msk[i] = '0; m_if[i] = '0;
        end
        exp_valid = 1'b0; exp_addr = '0; exp_if = '0; exp_ps = '0;
    endtask

    // Drive one cycle, advance the model, and compare all outputs to it.
    task automatic apply(input op_e op, input logic [7:0] idx, input logic [31:0] d,
                         input logic [31:0] m, input logic [3:0] f, input string tag);
        rst          = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_index = idx;
        case (op)
            OP_WR:  begin bus.wr_en = 1'b1; bus.addr_in = {f, m, d}; end
            OP_LK:  bus.addr_in = {4'($urandom), 32'($urandom), d};
            default: begin rst = 1'b1; bus.wr_en = 1'b1; bus.addr_in = {f, m, d}; end
        endcase
        @(posedge clk);
        #1;
        case (op)
            OP_WR: begin
                if (int'(idx) < SIZE) begin
                    m_vld[idx] = (f != 4'hF);
                    m_pre[idx] = d; m_msk[idx] = m; m_if[idx] = f;
                end
                exp_valid = 1'b0;
            end
            OP_LK:   model_lookup(d);
            default: model_reset();
        endcase
        rst = 1'b0;
        check({tag, " valid"},       32'(bus.valid),       32'(exp_valid));
        check({tag, " addr_out"},    bus.addr_out,         exp_addr);
        check({tag, " if_idx"},      32'(bus.if_idx),      32'(exp_if));
        check({tag, " prefix_size"}, 32'(bus.prefix_size), 32'(exp_ps));
    endtask

    initial begin
        logic [31:0] bases [4];
        logic [31:0] d, m;
        int          len;

        rst = 1'b1; bus.wr_en = 1'b0; bus.wr_index = '0; bus.addr_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Directed table with hand-derived results.
        add(OP_RST, 8'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A80001, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_WR,  8'd0, 32'hC0A80000, 32'hFFFFFF00, 4'h1, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_WR,  8'd1, 32'hC0A80000, 32'hFFFFFFE0, 4'h2, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_WR,  8'd2, 32'h00000000, 32'h00000000, 4'h3, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_WR,  8'd3, 32'hC0A80020, 32'hFFFFFFF0, 4'h4, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A80001, 32'h0, 4'h0, 1'b1, 32'hC0A80000, 4'h2, 8'd27);
        add(OP_LK,  8'd0, 32'hC0A80021, 32'h0, 4'h0, 1'b1, 32'hC0A80020, 4'h4, 8'd28);
        add(OP_LK,  8'd0, 32'hC0A8007E, 32'h0, 4'h0, 1'b1, 32'hC0A80000, 4'h1, 8'd24);
        add(OP_LK,  8'd0, 32'h0A00000A, 32'h0, 4'h0, 1'b1, 32'h00000000, 4'h3, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A80101, 32'h0, 4'h0, 1'b1, 32'h00000000, 4'h3, 8'd0);
        add(OP_WR,  8'd5, 32'hC0A80000, 32'hFFFFFF00, 4'h6, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A8007E, 32'h0, 4'h0, 1'b1, 32'hC0A80000, 4'h1, 8'd24);
        add(OP_WR,  8'd0, 32'hC0A80000, 32'hFFFFFF00, 4'hF, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A8007E, 32'h0, 4'h0, 1'b1, 32'hC0A80000, 4'h6, 8'd24);
        add(OP_WR,  8'd8, 32'hC0A8007E, 32'hFFFFFFFF, 4'h9, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A8007E, 32'h0, 4'h0, 1'b1, 32'hC0A80000, 4'h6, 8'd24);
        add(OP_WR,  8'd6, 32'hC0A80040, 32'hFFFFFFC0, 4'h7, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A80041, 32'h0, 4'h0, 1'b1, 32'hC0A80040, 4'h7, 8'd26);
        add(OP_LK,  8'd0, 32'hC0A80021, 32'h0, 4'h0, 1'b1, 32'hC0A80020, 4'h4, 8'd28);
        add(OP_LK,  8'd0, 32'h0A00000A, 32'h0, 4'h0, 1'b1, 32'h00000000, 4'h3, 8'd0);
        // Reset with a write also pending: reset must win, table ends up empty.
        add(OP_RST, 8'd7, 32'hC0A80001, 32'hFFFFFFFF, 4'h5, 1'b0, 32'h0, 4'h0, 8'd0);
        add(OP_LK,  8'd0, 32'hC0A80001, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 8'd0);

        foreach (tbl[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            apply(tbl[k].op, tbl[k].idx, tbl[k].d, tbl[k].m, tbl[k].f, tag);
            check({tag, " tbl valid"}, 32'(bus.valid), 32'(tbl[k].e_valid));
            if (tbl[k].op != OP_WR) begin
                check({tag, " tbl addr_out"},    bus.addr_out,         tbl[k].e_addr);
                check({tag, " tbl if_idx"},      32'(bus.if_idx),      32'(tbl[k].e_if));
                check({tag, " tbl prefix_size"}, 32'(bus.prefix_size), 32'(tbl[k].e_ps));
            end
        end

        // Randomized traffic against the model. Prefixes and addresses come
        // from a few shared bases so that matches and ties are frequent.
        bases[0] = 32'hC0A80000; bases[1] = 32'h0A000000;
        bases[2] = 32'hAC100000; bases[3] = 32'h00000000;
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                apply(OP_RST, 8'd0, 32'h0, 32'h0, 4'h0, $sformatf("rnd%0d rst", n));
            end else if (r < 40) begin
                d = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) begin
                    m = $urandom;
                end else begin
                    len = $urandom_range(0, 32);
                    m   = (len == 0) ? 32'h0 : (32'hFFFFFFFF << (32 - len));
                end
                apply(OP_WR, 8'($urandom_range(0, 9)), d, m, 4'($urandom_range(0, 15)),
                      $sformatf("rnd%0d wr", n));
            end else begin
                if ($urandom_range(0, 4) == 0) d = $urandom;
                else d = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 255));
                apply(OP_LK, 8'd0, d, 32'h0, 4'h0, $sformatf("rnd%0d lk", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
